// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: turns a stream of 32-bit big-endian message words into
// padded 16-word blocks, appending the 0x80 marker and the 64-bit bit length.
//
// state | meaning
// IDLE  | waiting for a new message, in_ready_o low
// START | one-cycle start_o pulse for the next block
// DATA  | accepting message words, one emitted per accepted word
// PAD   | emitting the 0x80 marker (if still owed) and zero words
// LEN   | emitting bit length high word (W14) then low word (W15)
// WAIT  | block handed off, waiting for blk_done_i
module sha256_msg_padder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_data_i,
  input  logic        in_last_i,
  input  logic [2:0]  in_bytes_i,
  output logic        start_o,
  output logic        msg_word_valid_o,
  output logic [31:0] msg_word_o,
  output logic        block_last_o,
  input  logic        blk_done_i,
  output logic        msg_done_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAD, S_LEN, S_WAIT} state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [63:0] bit_cnt;
  logic        data_done;
  logic        need_80;
  logic        pad80_done;
  logic        final_blk;

  logic        last_full;
  logic [63:0] bits_add;

  function automatic logic [31:0] pad_last(input logic [31:0] d, input logic [2:0] b);
    case (b)
      3'd0:    pad_last = 32'h8000_0000;
      3'd1:    pad_last = {d[31:24], 24'h80_0000};
      3'd2:    pad_last = {d[31:16], 16'h8000};
      3'd3:    pad_last = {d[31:8], 8'h80};
      default: pad_last = d;
    endcase
  endfunction

  // counts above 4 are treated as a full word
  assign last_full  = (in_bytes_i >= 3'd4);
  assign bits_add   = (in_last_i && !last_full) ? {58'd0, in_bytes_i, 3'b000} : 64'd32;
  assign in_ready_o = (state == S_DATA);
  assign busy_o     = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      idx              <= 4'd0;
      bit_cnt          <= 64'd0;
      data_done        <= 1'b0;
      need_80          <= 1'b0;
      pad80_done       <= 1'b0;
      final_blk        <= 1'b0;
      start_o          <= 1'b0;
      msg_word_valid_o <= 1'b0;
      msg_word_o       <= 32'd0;
      block_last_o     <= 1'b0;
      msg_done_o       <= 1'b0;
    end else begin
      start_o          <= 1'b0;
      msg_word_valid_o <= 1'b0;
      block_last_o     <= 1'b0;
      msg_done_o       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid_i) begin
            state      <= S_START;
            start_o    <= 1'b1;
            idx        <= 4'd0;
            bit_cnt    <= 64'd0;
            data_done  <= 1'b0;
            need_80    <= 1'b0;
            pad80_done <= 1'b0;
            final_blk  <= 1'b0;
          end
        end
        S_START: begin
          state <= data_done ? S_PAD : S_DATA;
        end
        S_DATA: begin
          if (in_valid_i) begin
            msg_word_valid_o <= 1'b1;
            idx              <= idx + 4'd1;
            bit_cnt          <= bit_cnt + bits_add;
            if (!in_last_i) begin
              msg_word_o <= in_data_i;
              if (idx == 4'd15) state <= S_WAIT;
            end else if (last_full) begin
              // marker is owed as a separate word, possibly in the next block
              data_done  <= 1'b1;
              msg_word_o <= in_data_i;
              need_80    <= 1'b1;
              state      <= (idx == 4'd15) ? S_WAIT : S_PAD;
            end else begin
              data_done  <= 1'b1;
              msg_word_o <= pad_last(in_data_i, in_bytes_i);
              pad80_done <= 1'b1;
              if (idx == 4'd15)      state <= S_WAIT;
              else if (idx == 4'd13) state <= S_LEN;
              else                   state <= S_PAD;
            end
          end
        end
        S_PAD: begin
          msg_word_valid_o <= 1'b1;
          idx              <= idx + 4'd1;
          msg_word_o       <= need_80 ? 32'h8000_0000 : 32'd0;
          if (need_80) begin
            need_80    <= 1'b0;
            pad80_done <= 1'b1;
          end
          // length only fits if the marker is already out by W13
          if (idx == 4'd15)                             state <= S_WAIT;
          else if (idx == 4'd13 && (pad80_done || need_80)) state <= S_LEN;
        end
        S_LEN: begin
          msg_word_valid_o <= 1'b1;
          idx              <= idx + 4'd1;
          if (idx == 4'd15) begin
            msg_word_o   <= bit_cnt[31:0];
            block_last_o <= 1'b1;
            final_blk    <= 1'b1;
            state        <= S_WAIT;
          end else begin
            msg_word_o <= bit_cnt[63:32];
          end
        end
        S_WAIT: begin
          if (blk_done_i) begin
            if (final_blk) begin
              state      <= S_IDLE;
              msg_done_o <= 1'b1;
            end else begin
              state   <= S_START;
              start_o <= 1'b1;
              idx     <= 4'd0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
